// File: rtl/multiword_add_seq_pkg.sv
// Shared definitions for the multiword_add_seq sequencer: FSM state encoding
// and the width of the reused adder slice.
package multiword_add_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int SLICE_W = 4;

endpackage

// File: rtl/multiword_add_seq_add_slice4.sv
// add_slice4: combinational 4-bit ripple-carry adder made of four full-adder
// cells. This is the only adder in the sequencer; it is reused every step.
//   x, y  : nibble operands
//   cin   : carry into bit 0
//   sum   : nibble result
//   cout  : carry out of bit 3
module add_slice4
  import multiword_add_seq_pkg::*;
(
  input  logic [SLICE_W-1:0] x,
  input  logic [SLICE_W-1:0] y,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);

  logic [SLICE_W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < SLICE_W; i++) begin : g_fa
    assign sum[i]  = x[i] ^ y[i] ^ c[i];
    assign c[i+1]  = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end

  assign cout = c[SLICE_W];

endmodule

// File: rtl/multiword_add_seq.sv
// multiword_add_seq: adds or subtracts two WIDTH-bit operands using a single
// 4-bit ripple slice over NSLICE = WIDTH/4 cycles, least-significant nibble
// first, with the inter-slice carry held in a register.
// WIDTH must be a multiple of 4 and at least 8.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid/in_ready    : request handshake (accepted only in IDLE)
//   a, b, cin, sub       : operands, carry-in (ignored on sub), subtract select
//   out_valid/out_ready  : result handshake (held in DONE until accepted)
//   sum, cout, ovf       : result, carry out of MSB, signed overflow
module multiword_add_seq
  import multiword_add_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic [SLICE_W-1:0] s_sum;
  logic               s_cout;
  logic               last_step;

  add_slice4 u_slice (
    .x    (a_q[SLICE_W-1:0]),
    .y    (b_q[SLICE_W-1:0]),
    .cin  (carry_q),
    .sum  (s_sum),
    .cout (s_cout)
  );

  assign last_step = (cnt_q == CNT_W'(NSLICE - 1));

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last_step) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          // Subtraction is a + ~b + 1; the +1 rides in on the carry register.
          b_d     = sub ? ~b : b;
          carry_d = sub | cin;
          cnt_d   = '0;
        end
      end
      RUN: begin
        // Result fills from the top so the first (low) nibble ends at bit 0.
        res_d   = {s_sum, res_q[WIDTH-1:SLICE_W]};
        a_d     = a_q >> SLICE_W;
        b_d     = b_q >> SLICE_W;
        carry_d = s_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_step) begin
          cout_d = s_cout;
          // Carry into the MSB xor carry out of it.
          ovf_d  = a_q[SLICE_W-1] ^ b_q[SLICE_W-1] ^ s_sum[SLICE_W-1] ^ s_cout;
        end
      end
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    sum       = res_q;
    cout      = cout_q;
    ovf       = ovf_q;
  end

endmodule

// File: tb/tb_multiword_add_seq.sv
module tb_multiword_add_seq;

  localparam int WIDTH  = 16;
  localparam int NSLICE = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multiword_add_seq #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain wide arithmetic. Returns {ovf, cout, sum}.
  function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                        input logic mci, input logic msub);
    logic [15:0] bb;
    logic [16:0] full;
    logic        o;
    bb   = msub ? ~mb : mb;
    full = {1'b0, ma} + {1'b0, bb} + {16'b0, (msub ? 1'b1 : mci)};
    o    = (ma[15] == bb[15]) && (full[15] != ma[15]);
    return {o, full[16], full[15:0]};
  endfunction

  // One full request/response with out_ready held high. Latency counts cycles
  // from the handshake cycle (0) to the first cycle with out_valid=1.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb, input logic tci,
                        input logic ts, output logic [15:0] rs, output logic rc,
                        output logic ro, output int lat);
    int w;
    @(negedge clk);
    a = ta; b = tb; cin = tci; sub = ts; in_valid = 1'b1; out_ready = 1'b1;
    w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    // Scramble inputs after the accept; they must be ignored.
    in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom); cin = ~tci; sub = ~ts;
    lat = 1;
    while (!out_valid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) chk("result_timeout", 32'(out_valid), 32'd1);
    rs = sum; rc = cout; ro = ovf;
    @(posedge clk);
    @(negedge clk);
    chk("idle_after_xfer_in_ready", 32'(in_ready), 32'd1);
    chk("idle_after_xfer_out_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    vec_t        vt[6];
    logic [15:0] rs;
    logic        rc, ro;
    int          lat;
    logic [17:0] e;

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;

    // Spec vectors plus a couple of edge cases (add overflow, 0 - 0).
    vt[0] = '{16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0};
    vt[1] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    vt[2] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vt[3] = '{16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vt[4] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vt[5] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);

    // Directed table
    for (int i = 0; i < 6; i++) begin
      run_op(vt[i].a, vt[i].b, vt[i].cin, vt[i].sub, rs, rc, ro, lat);
      chk($sformatf("vec%0d_sum", i), 32'(rs), 32'(vt[i].sum));
      chk($sformatf("vec%0d_cout", i), 32'(rc), 32'(vt[i].cout));
      chk($sformatf("vec%0d_ovf", i), 32'(ro), 32'(vt[i].ovf));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(NSLICE + 1));
    end

    // Randomized against the reference model
    for (int i = 0; i < 40; i++) begin
      logic [15:0] ra, rb;
      logic        rci, rsb;
      ra = 16'($urandom); rb = 16'($urandom);
      rci = 1'($urandom); rsb = 1'($urandom);
      e = model(ra, rb, rci, rsb);
      run_op(ra, rb, rci, rsb, rs, rc, ro, lat);
      chk($sformatf("rnd%0d_res", i), 32'({ro, rc, rs}), 32'(e));
    end

    // Backpressure: result held for 6 cycles, competing request ignored
    begin
      int w;
      @(negedge clk);
      a = 16'h1234; b = 16'h4321; cin = 1'b0; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      w = 0;
      while (!out_valid && w < 30) begin
        @(negedge clk);
        w++;
      end
      chk("bp_out_valid_rise", 32'(out_valid), 32'd1);
      for (int k = 0; k < 6; k++) begin
        chk($sformatf("bp%0d_sum", k), 32'(sum), 32'h5555);
        chk($sformatf("bp%0d_cout_ovf", k), 32'({cout, ovf}), 32'd0);
        chk($sformatf("bp%0d_out_valid", k), 32'(out_valid), 32'd1);
        chk($sformatf("bp%0d_in_ready", k), 32'(in_ready), 32'd0);
        in_valid = 1'b1; a = 16'hAAAA; b = 16'h0F0F; out_ready = 1'b0;
        @(negedge clk);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_out_valid", 32'(out_valid), 32'd0);
      chk("bp_release_idle", 32'(in_ready), 32'd1);
    end

    // Reset mid-RUN abandons the operation
    begin
      int pulses;
      @(negedge clk);
      a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_in_ready", 32'(in_ready), 32'd1);
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_sum", 32'(sum), 32'd0);
      pulses = 0;
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        if (out_valid) pulses++;
      end
      chk("midrst_no_pulse", 32'(pulses), 32'd0);
      run_op(16'h0001, 16'h0001, 1'b0, 1'b0, rs, rc, ro, lat);
      chk("post_rst_sum", 32'(rs), 32'h0002);
    end

    // Back-to-back with in_valid held high
    begin
      logic [17:0] expq[$];
      int          cyc, last, nacc, nres;
      logic        newops;
      cyc = 0; last = -1; nacc = 0; nres = 0; newops = 1'b0;
      @(negedge clk);
      a = 16'($urandom); b = 16'($urandom); cin = 1'b1; sub = 1'b0;
      in_valid = 1'b1; out_ready = 1'b1;
      while (nres < 6 && cyc < 300) begin
        if (newops) begin
          a = 16'($urandom); b = 16'($urandom);
          cin = 1'($urandom); sub = 1'($urandom);
          newops = 1'b0;
          if (nacc == 6) in_valid = 1'b0;
        end
        if (out_valid) begin
          if (expq.size() == 0) chk("b2b_unexpected_result", 32'(out_valid), 32'd0);
          else chk($sformatf("b2b%0d_res", nres), 32'({ovf, cout, sum}), 32'(expq.pop_front()));
          nres++;
        end
        if (in_ready && in_valid) begin
          if (last >= 0) chk($sformatf("b2b%0d_spacing", nacc), 32'(cyc - last), 32'(NSLICE + 2));
          last = cyc;
          expq.push_back(model(a, b, cin, sub));
          nacc++;
          newops = 1'b1;
        end
        @(negedge clk);
        cyc++;
      end
      if (nres < 6) chk("b2b_timeout", 32'(nres), 32'd6);
      in_valid = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multiword_add_seq.md
Name: multiword_add_seq

Overview:
- Sequencer that adds or subtracts two WIDTH-bit operands by reusing one 4-bit ripple-carry slice over WIDTH/4 cycles.
- Carry is registered between slices, least-significant nibble first.
- Sits between a requester (valid/ready) and a consumer (valid/ready) where a wide adder is too costly in area.
- Produces the sum, carry-out and signed overflow.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of 4 and >= 8.
- NSLICE, WIDTH/4, number of slice steps; derived, not overridable.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  request carries valid operands
- in_ready  output  1  sequencer can accept a request
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in; ignored when sub=1
- sub  input  1  1 = compute a - b (b inverted, carry-in forced to 1)
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result
- cout  output  1  carry out of MSB (for sub: 1 = no borrow)
- ovf  output  1  signed two's-complement overflow

Behaviour:
- Everything is synchronous to clk, and rst is sampled on the rising edge.
- Reset values: state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, ovf=0, step counter=0, carry reg=0.
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready=1. When in_valid=1, latch a into A-shift register and b (or ~b if sub) into B-shift register. Latch carry reg = sub ? 1 : cin. Clear counter, go to RUN.
  - RUN: in_ready=0. Each cycle, feed the low nibbles of the shift registers plus carry reg into the slice. Shift the slice sum into the top of the result register (result shifts right by 4), shift A/B right by 4, and load the carry reg with the slice carry-out. The counter increments; after step NSLICE-1, go to DONE.
  - DONE: out_valid=1. sum, cout and ovf are stable and held while out_ready=0. When out_ready=1, the result transfers that cycle; drop out_valid and return to IDLE.
- Latency: the request handshake occurs at cycle 0. out_valid rises in cycle NSLICE+1 (5 for WIDTH=16). Throughput is one operation per NSLICE+2 cycles minimum.
- in_ready is asserted only in IDLE. There is no accept during DONE, even when out_ready=1.
- ovf = (a_msb ^ b'_msb ^ sum_msb) ^ cout, where b' is the post-inversion operand. Compute it in the final RUN step and register it with sum and cout.
- The inputs a, b, cin and sub are sampled only at the accept cycle. Changes while not in IDLE are ignored.
- in_valid=0 in IDLE leaves the state unchanged.
- out_ready while not in DONE is ignored.
- Reset mid-operation (RUN or DONE) abandons the operation. The result is discarded, with no out_valid pulse, and the reset values above apply on the next cycle.
- Wrap-around: sum is modulo 2^WIDTH, and the carry out of the MSB appears only on cout.

Decomposition:
- Shared package holds:
  - The FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
  - The constant SLICE_W=4.
- Sub-module add_slice4: a combinational 4-bit ripple-carry adder slice.
  - Ports: x[3:0], y[3:0], cin, sum[3:0], cout.
  - Built from four full-adder cells.
  - Instantiated exactly once.
- Counter width is clog2(NSLICE).

Test Plan:
- Add, WIDTH=16: a=16'h1234, b=16'h1111, cin=0, sub=0 -> sum=16'h2345, cout=0, ovf=0; out_valid rises 5 cycles after accept.
- Carry ripple across all slices: a=16'hFFFF, b=16'h0000, cin=1 -> sum=16'h0000, cout=1, ovf=0.
- Subtract with signed overflow: a=16'h8000, b=16'h0001, sub=1 -> sum=16'h7FFF, cout=1, ovf=1. Also a=16'h0003, b=16'h0005, sub=1 -> sum=16'hFFFE, cout=0, ovf=0.
- Backpressure: hold out_ready=0 for 6 cycles in DONE.
  - sum, cout and ovf stay stable, with out_valid=1 and in_ready=0 throughout.
  - A new in_valid with different operands is not accepted.
  - Release out_ready -> one transfer, then IDLE.
- Reset mid-RUN: assert rst in cycle 2 after accept -> next cycle state=IDLE, in_ready=1, out_valid=0, sum=0. A following request a=16'h0001, b=16'h0001 yields sum=16'h0002.
- Back-to-back: in_valid held high with out_ready=1 -> accept every 6 cycles (NSLICE+2). Each result matches its own operands, with no carry leaking between operations.
